// File: rtl/aes_pkg.sv
// Shared types, constants and GF(2^8) helpers for the word-serial AES-128 encryption core.
package aes_pkg;

  localparam int NR = 10;
  localparam int NB = 4;

  typedef logic [7:0]  byte_t;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ROUND,
    ST_OUT
  } aes_state_e;

  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Row 0 lives in bits [31:24]; each output row is {2,3,1,1} rotated.
  function automatic word_t mix_column(input word_t w);
    byte_t a0, a1, a2, a3;
    byte_t r0, r1, r2, r3;
    a0 = w[31:24];
    a1 = w[23:16];
    a2 = w[15:8];
    a3 = w[7:0];
    r0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    r1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    r2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    r3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {r0, r1, r2, r3};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module aes_sbox
  import aes_pkg::*;
(
  input  byte_t in_i,
  output byte_t out_o
);

  // Entry 0 occupies the top byte, so entry a sits at bit 8*(255-a)+7.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign out_o = SBOX[{~in_i, 3'b111} -: 8];

endmodule

// File: rtl/aes_encrypt_core.sv
// Word-serial AES-128 encryptor reading round keys from key_expand one word per cycle.
// Optional debug ports and key-index assertion are enabled by defining AES_ROUND_DBG_EN.
module aes_encrypt_core
  import aes_pkg::*;
#(
  parameter int NR = aes_pkg::NR
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] data_in,
  input  logic        key_ready,
  input  logic [31:0] round_key,
  output logic [3:0]  round_key_num,
  output logic [1:0]  r_index,
  output logic [31:0] data_out,
  output logic        out_valid,
  output logic [1:0]  out_index,
  output logic        busy,
  output logic        aborted
`ifdef AES_ROUND_DBG_EN
  ,
  output logic [3:0]  dbg_round,
  output logic [31:0] dbg_col
`endif
);

  if (NR != 10) begin : g_nr_check
    $error("aes_encrypt_core supports only NR = 10 (AES-128)");
  end

  localparam logic [3:0] LAST_RND = 4'(NR);

  aes_state_e  state_q;
  logic [3:0]  round_q;
  logic [1:0]  col_q;
  word_t       st_q [NB];
  word_t       sh_q [NB];
  word_t       data_out_q;
  logic        out_valid_q;
  logic [1:0]  out_index_q;
  logic        busy_q;
  logic        aborted_q;

  byte_t       sb_in  [NB];
  byte_t       sb_out [NB];
  word_t       sub_w;
  word_t       col_w;
  word_t       load_w;

  // ShiftRows folded into the S-box read: row j comes from column (c+j) mod 4.
  always_comb begin
    for (int j = 0; j < NB; j++) begin
      sb_in[j] = st_q[col_q + 2'(j)][31-8*j -: 8];
    end
  end

  for (genvar g = 0; g < NB; g++) begin : g_sbox
    aes_sbox u_sbox (
      .in_i  (sb_in[g]),
      .out_o (sb_out[g])
    );
  end

  assign sub_w  = {sb_out[0], sb_out[1], sb_out[2], sb_out[3]};
  assign col_w  = ((round_q == LAST_RND) ? sub_w : mix_column(sub_w)) ^ round_key;
  assign load_w = data_in ^ round_key;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      round_q     <= '0;
      col_q       <= '0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      out_index_q <= '0;
      busy_q      <= 1'b0;
      aborted_q   <= 1'b0;
      for (int i = 0; i < NB; i++) begin
        st_q[i] <= '0;
        sh_q[i] <= '0;
      end
    end else if ((state_q == ST_LOAD || state_q == ST_ROUND) && !key_ready) begin
      // Round keys went stale underneath us: drop the block entirely.
      state_q   <= ST_IDLE;
      round_q   <= '0;
      col_q     <= '0;
      busy_q    <= 1'b0;
      aborted_q <= 1'b1;
      for (int i = 0; i < NB; i++) begin
        st_q[i] <= '0;
        sh_q[i] <= '0;
      end
    end else begin
      aborted_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start && key_ready) begin
            state_q <= ST_LOAD;
            busy_q  <= 1'b1;
            round_q <= '0;
            col_q   <= '0;
          end
        end
        ST_LOAD: begin
          st_q[col_q] <= load_w;
          col_q       <= col_q + 2'd1;
          if (col_q == 2'd3) begin
            state_q <= ST_ROUND;
            round_q <= 4'd1;
          end
        end
        ST_ROUND: begin
          sh_q[col_q] <= col_w;
          col_q       <= col_q + 2'd1;
          if (col_q == 2'd3) begin
            st_q[0] <= sh_q[0];
            st_q[1] <= sh_q[1];
            st_q[2] <= sh_q[2];
            st_q[3] <= col_w;
            if (round_q == LAST_RND) begin
              // Word 0 is final in the shadow buffer already, so emit it now.
              state_q     <= ST_OUT;
              round_q     <= '0;
              out_valid_q <= 1'b1;
              out_index_q <= '0;
              data_out_q  <= sh_q[0];
            end else begin
              round_q <= round_q + 4'd1;
            end
          end
        end
        ST_OUT: begin
          if (out_index_q == 2'd3) begin
            out_valid_q <= 1'b0;
            out_index_q <= '0;
            data_out_q  <= '0;
            if (start && key_ready) begin
              state_q <= ST_LOAD;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            out_index_q <= out_index_q + 2'd1;
            data_out_q  <= st_q[out_index_q + 2'd1];
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign round_key_num = round_q;
  assign r_index       = col_q;
  assign data_out      = data_out_q;
  assign out_valid     = out_valid_q;
  assign out_index     = out_index_q;
  assign busy          = busy_q;
  assign aborted       = aborted_q;

`ifdef AES_ROUND_DBG_EN
  assign dbg_round = round_q;
  assign dbg_col   = (state_q == ST_LOAD)  ? load_w :
                     (state_q == ST_ROUND) ? col_w  : '0;

  always @(posedge clk) begin
    if (!reset) begin
      assert (round_key_num <= LAST_RND)
        else $error("round_key_num %0d exceeds NR", round_key_num);
    end
  end
`endif

endmodule
